aes_cipher_iter: RTL and testbench

- Iterative AES forward cipher (encryptor): one round per clock, reusing one round datapath. It is the encrypt-direction counterpart to the pipelined inverse cipher.
- Sits after the key expansion block, which supplies the round-key array, and talks valid/ready to the upstream and downstream blocks.
- Built for area-constrained configurations where one block every Nr+2 cycles is enough throughput.

---
 rtl/aes_cipher_iter.sv | 237 +++++++++++++++++++++++
 tb/tb_aes_cipher_iter.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_cipher_iter.sv
// ---------------------------------------------------------------------------
// aes_cipher_iter -- iterative AES forward cipher, one round per clock.
//
// A single round datapath (SubBytes -> ShiftRows -> MixColumns -> AddRoundKey)
// is reused for every round. Round 0 (the initial AddRoundKey) is folded into
// the accept cycle, so one block takes Nr+2 cycles end to end: the accept
// cycle, Nr round cycles and one DONE cycle.
//
// Byte order: bit [127:120] of a 128-bit state is state byte 0 (row 0,
// column 0). Bytes run down each column, then across columns. This is the
// same order the inverse cipher uses.
//
// Parameters:
//   Nk  key length in 32-bit words (4, 6 or 8)
//   Nr  number of rounds, always Nk+6 (not overridable)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   plaintext offered
//   in_ready   block is idle and can take plaintext
//   pt         plaintext, sampled only on an accept
//   rkey       expanded key words; round i key =
//              {rkey[4i+3], rkey[4i+2], rkey[4i+1], rkey[4i+0]}.
//              Must stay stable from the accept until out_valid.
//   out_valid  ciphertext available
//   out_ready  downstream takes the ciphertext
//   ct         ciphertext (registered state)
//   busy       high while a block is in flight or waiting in DONE
//
// Build option:
//   AES_CIPHER_ZEROIZE_EN  when defined, the state register is cleared on the
//                          output handshake and ct reads 0 whenever out_valid
//                          is low, so intermediate round state never leaves
//                          the block.
// ---------------------------------------------------------------------------

package aes_pkg;

  // Forward S-box, entry 0 in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] lo;
    lo = 11'd2040 - {b, 3'b000};
    return SBOX_TBL[lo +: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) begin
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    end
    return o;
  endfunction

  // Row r of column c moves from column (c + r) mod 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      o[127 - 32*c -: 32] = mix_col(s[127 - 32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] k);
    return s ^ k;
  endfunction

endpackage

// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | waiting for plaintext; accept applies round-0 key
// S_ROUND | round round_q in progress (1..Nr); Nr is the final round
// S_DONE  | ciphertext presented, held until out_ready
module aes_cipher_iter #(
  parameter  int Nk = 4,
  localparam int Nr = Nk + 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt,
  input  logic [31:0]  rkey [4*(Nr+1)],
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct,
  output logic         busy
);
  import aes_pkg::*;

  localparam int RW = $clog2(Nr + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ROUND = 2'd1,
    S_DONE  = 2'd2
  } fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [RW-1:0] round_q, round_d;
  logic [127:0]  state_q, state_d;

  logic [127:0]  rk_cur;
  logic [127:0]  sr_out;
  logic [127:0]  mc_out;
  logic [127:0]  round_out;
  logic          last_round;

  // round_q is 0 in IDLE, so the same selector yields the round-0 key for the
  // accept and key r while round r runs. Word index = {round, word-in-round}.
  assign rk_cur = {rkey[{round_q, 2'd3}], rkey[{round_q, 2'd2}],
                   rkey[{round_q, 2'd1}], rkey[{round_q, 2'd0}]};

  assign last_round = (round_q == RW'(Nr));
  assign sr_out     = shift_rows(sub_bytes(state_q));
  assign mc_out     = mix_columns(sr_out);
  assign round_out  = add_round_key(last_round ? sr_out : mc_out, rk_cur);

  always_comb begin
    fsm_d   = fsm_q;
    round_d = round_q;
    state_d = state_q;
    case (fsm_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = add_round_key(pt, rk_cur);
          round_d = RW'(1);
          fsm_d   = S_ROUND;
        end
      end
      S_ROUND: begin
        state_d = round_out;
        if (last_round) begin
          fsm_d = S_DONE;
        end else begin
          round_d = round_q + RW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          fsm_d   = S_IDLE;
          round_d = '0;
`ifdef AES_CIPHER_ZEROIZE_EN
          state_d = '0;
`endif
        end
      end
      default: begin
        fsm_d   = S_IDLE;
        round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= S_IDLE;
      round_q <= '0;
      state_q <= '0;
    end else begin
      fsm_q   <= fsm_d;
      round_q <= round_d;
      state_q <= state_d;
    end
  end

  assign in_ready  = (fsm_q == S_IDLE);
  assign out_valid = (fsm_q == S_DONE);
  assign busy      = (fsm_q != S_IDLE);

`ifdef AES_CIPHER_ZEROIZE_EN
  assign ct = out_valid ? state_q : '0;
`else
  assign ct = state_q;
`endif

`ifndef SYNTHESIS
  a_pt_known: assert property (@(posedge clk) disable iff (!rst_n)
    (in_valid && in_ready) |-> !$isunknown(pt));

  for (genvar g = 0; g < 4*(Nr+1); g++) begin : g_rkey_known
    a_rkey_known: assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid && in_ready) |-> !$isunknown(rkey[g]));
  end

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(ct)));

  a_round_max: assert property (@(posedge clk) disable iff (!rst_n)
    round_q <= RW'(Nr));
`endif

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: three instances (Nk = 4, 6, 8) sharing clock,
// reset, plaintext bus and out_ready. Cycles are counted from the accept
// cycle (cycle 0, in_valid high while in_ready); the first round runs in
// cycle 1 and out_valid is expected in cycle Nr+1.
module tb_aes_cipher_iter;

`ifdef AES_CIPHER_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         out_ready;
  logic [127:0] pt;
  logic         iv4, iv6, iv8;
  logic         ir4, ir6, ir8;
  logic         ov4, ov6, ov8;
  logic         bz4, bz6, bz8;
  logic [127:0] ct4, ct6, ct8;
  logic [31:0]  rk4 [44];
  logic [31:0]  rk6 [52];
  logic [31:0]  rk8 [60];

  aes_cipher_iter #(.Nk(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .pt(pt),
    .rkey(rk4), .out_valid(ov4), .out_ready(out_ready), .ct(ct4), .busy(bz4));
  aes_cipher_iter #(.Nk(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv6), .in_ready(ir6), .pt(pt),
    .rkey(rk6), .out_valid(ov6), .out_ready(out_ready), .ct(ct6), .busy(bz6));
  aes_cipher_iter #(.Nk(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .pt(pt),
    .rkey(rk8), .out_valid(ov8), .out_ready(out_ready), .ct(ct8), .busy(bz8));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (GF arithmetic, not a lookup copy) ----
  logic [7:0]  sbox_t     [256];
  logic [7:0]  inv_sbox_t [256];
  logic [31:0] w_g        [60];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gm(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
          {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_t[a]     = s;
      inv_sbox_t[s] = 8'(a);
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
  endfunction

  // Key words are left-aligned in 'key': word i = key[255-32i -: 32].
  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4*(nk+7); i++) begin
      if (i < nk) begin
        w_g[i] = key[255 - 32*i -: 32];
      end else begin
        t = w_g[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = xt(rc);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w_g[i] = w_g[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [127:0] rkm(input int r);
    return {w_g[4*r], w_g[4*r+1], w_g[4*r+2], w_g[4*r+3]};
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox_t[s[8*i +: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      {a0, a1, a2, a3} = s[127 - 32*c -: 32];
      o[127 - 32*c -: 32] = {
        gm(a0, 8'h0e) ^ gm(a1, 8'h0b) ^ gm(a2, 8'h0d) ^ gm(a3, 8'h09),
        gm(a0, 8'h09) ^ gm(a1, 8'h0e) ^ gm(a2, 8'h0b) ^ gm(a3, 8'h0d),
        gm(a0, 8'h0d) ^ gm(a1, 8'h09) ^ gm(a2, 8'h0e) ^ gm(a3, 8'h0b),
        gm(a0, 8'h0b) ^ gm(a1, 8'h0d) ^ gm(a2, 8'h09) ^ gm(a3, 8'h0e)};
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_cipher(input logic [127:0] c, input int nr);
    logic [127:0] s;
    s = c ^ rkm(nr);
    for (int r = nr - 1; r >= 1; r--) s = inv_mix(inv_sub(inv_shift(s)) ^ rkm(r));
    return inv_sub(inv_shift(s)) ^ rkm(0);
  endfunction

  // ---------------- per-instance access ----------------
  function automatic logic [2:0] get_st(input int nk);  // {out_valid, in_ready, busy}
    case (nk)
      6:       return {ov6, ir6, bz6};
      8:       return {ov8, ir8, bz8};
      default: return {ov4, ir4, bz4};
    endcase
  endfunction

  function automatic logic [127:0] get_ct(input int nk);
    case (nk)
      6:       return ct6;
      8:       return ct8;
      default: return ct4;
    endcase
  endfunction

  task automatic set_iv(input int nk, input logic v);
    case (nk)
      6:       iv6 = v;
      8:       iv8 = v;
      default: iv4 = v;
    endcase
  endtask

  // rkey[4r+j] holds FIPS word w[4r+3-j].
  task automatic load_key(input int nk, input logic [255:0] key);
    logic [31:0] wd;
    expand(key, nk);
    for (int i = 0; i < 4*(nk+7); i++) begin
      wd = w_g[4*(i/4) + 3 - (i%4)];
      case (nk)
        6:       rk6[i] = wd;
        8:       rk8[i] = wd;
        default: rk4[i] = wd;
      endcase
    end
  endtask

  // One block through instance nk. poke_at: cycle at which an all-ones pt is
  // offered while busy. rst_at: cycle at which reset is pulsed (lat = -2).
  task automatic run_block(input int nk, input logic [255:0] key, input logic [127:0] ptv,
                           input int poke_at, input int rst_at,
                           output logic [127:0] ctv, output int lat);
    int         cyc;
    logic       stop, seen;
    logic [2:0] st;
    load_key(nk, key);
    @(negedge clk);
    chk("idle_before_accept", 160'(get_st(nk)), 160'(3'b010));
    pt = ptv;
    set_iv(nk, 1'b1);
    lat  = -1;
    ctv  = '0;
    cyc  = 0;
    stop = 1'b0;
    while (!stop && cyc < 40) begin
      @(negedge clk);
      cyc++;
      set_iv(nk, 1'b0);
      pt = ~ptv;
      if (cyc == poke_at) begin
        pt = '1;
        set_iv(nk, 1'b1);
      end
      st = get_st(nk);
      if (cyc == 1) begin
        chk("round1_flags", 160'(st), 160'(3'b001));
        chk("round1_ct", 160'(get_ct(nk)), 160'(ZEROIZE ? 128'h0 : (ptv ^ key[255:128])));
      end
      if (cyc == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("abort_flags", 160'(get_st(nk)), 160'(3'b010));
        chk("abort_ct", 160'(get_ct(nk)), 160'(0));
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (nk + 10) begin
          @(negedge clk);
          st   = get_st(nk);
          seen = seen | st[2];
        end
        chk("abort_no_out_valid", 160'(seen), 160'(0));
        lat  = -2;
        stop = 1'b1;
      end else if (st[2]) begin
        lat  = cyc;
        ctv  = get_ct(nk);
        stop = 1'b1;
      end
`ifdef AES_CIPHER_ZEROIZE_EN
      else begin
        chk("ct_gated_zero", 160'(get_ct(nk)), 160'(0));
      end
`endif
    end
    n_checks++;
    if (lat == -1) begin
      n_errors++;
      $display("FAIL latency_timeout: out_valid not seen in 40 cycles, required at cycle %0d", nk + 7);
    end
    if (lat > 0 && out_ready) begin
      @(negedge clk);
      chk("post_handshake_flags", 160'(get_st(nk)), 160'(3'b010));
      chk("post_handshake_ct", 160'(get_ct(nk)), 160'(ZEROIZE ? 128'h0 : ctv));
    end
  endtask

  typedef struct {
    int           nk;
    logic [255:0] key;
    logic [127:0] ptxt;
    logic [127:0] ctxt;
  } vec_t;

  vec_t vecs [6];

  initial begin
    logic [127:0] ctv, ptv, c1;
    logic [255:0] key;
    int           lat, nk;

    vecs[0] = '{4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a};
    vecs[1] = '{6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                128'h00112233445566778899aabbccddeeff, 128'hdda97ca4864cdfe06eaf70a0ec0d7191};
    vecs[2] = '{8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                128'h00112233445566778899aabbccddeeff, 128'h8ea2b7ca516745bfeafc49904b496089};
    vecs[3] = '{4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32};
    vecs[4] = '{4, 256'h0, 128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e};
    vecs[5] = '{8, 256'h0, 128'h0, 128'hdc95c078a2408989ad48a21492842087};
    c1 = vecs[0].ctxt;

    build_sbox();
    rst_n     = 1'b0;
    out_ready = 1'b1;
    pt        = '0;
    iv4 = 1'b0; iv6 = 1'b0; iv8 = 1'b0;
    for (int i = 0; i < 44; i++) rk4[i] = '0;
    for (int i = 0; i < 52; i++) rk6[i] = '0;
    for (int i = 0; i < 60; i++) rk8[i] = '0;

    repeat (2) @(negedge clk);
    chk("reset_flags4", 160'({ov4, ir4, bz4}), 160'(3'b010));
    chk("reset_ct4", 160'(ct4), 160'(0));
    chk("reset_flags68", 160'({ov6, ir6, bz6, ov8, ir8, bz8}), 160'(6'b010010));
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].nk, vecs[i].key, vecs[i].ptxt, -1, -1, ctv, lat);
      chk($sformatf("vec%0d_ct", i), 160'(ctv), 160'(vecs[i].ctxt));
      chk($sformatf("vec%0d_latency", i), 160'(lat), 160'(vecs[i].nk + 7));
      chk($sformatf("vec%0d_roundtrip", i), 160'(inv_cipher(ctv, vecs[i].nk + 6)),
          160'(vecs[i].ptxt));
    end

    // Backpressure: hold DONE for 20 further cycles.
    out_ready = 1'b0;
    run_block(4, vecs[0].key, vecs[0].ptxt, -1, -1, ctv, lat);
    chk("bp_ct", 160'(ctv), 160'(c1));
    chk("bp_latency", 160'(lat), 160'(11));
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("bp_hold", 160'({ov4, ir4, bz4, ct4}), 160'({3'b101, c1}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_flags", 160'({ov4, ir4, bz4}), 160'(3'b010));
    chk("bp_release_ct", 160'(ct4), 160'(ZEROIZE ? 128'h0 : c1));

    // in_valid with a different pt while busy must be ignored.
    run_block(4, vecs[0].key, vecs[0].ptxt, 3, -1, ctv, lat);
    chk("busy_ignore_ct", 160'(ctv), 160'(c1));
    chk("busy_ignore_latency", 160'(lat), 160'(11));

    // Reset in the middle of round processing, then a clean block.
    run_block(4, vecs[0].key, vecs[0].ptxt, -1, 5, ctv, lat);
    run_block(4, vecs[0].key, vecs[0].ptxt, -1, -1, ctv, lat);
    chk("after_abort_ct", 160'(ctv), 160'(c1));
    chk("after_abort_latency", 160'(lat), 160'(11));

    // Random round trips across all key sizes.
    for (int i = 0; i < 100; i++) begin
      nk  = (i % 3 == 0) ? 4 : ((i % 3 == 1) ? 6 : 8);
      key = {$urandom(), $urandom(), $urandom(), $urandom(),
             $urandom(), $urandom(), $urandom(), $urandom()};
      ptv = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(nk, key, ptv, -1, -1, ctv, lat);
      chk($sformatf("rt%0d_latency", i), 160'(lat), 160'(nk + 7));
      chk($sformatf("rt%0d_plaintext", i), 160'(inv_cipher(ctv, nk + 6)), 160'(ptv));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_errors);
    $fatal(1);
  end

endmodule
